seq_det_ctrl: RTL and testbench

Programmable serial pattern-detection controller for the team's FSM detector family; generalises the fixed 1011 Mealy detector to a runtime-configured pattern of 1..PAT_W bits, with overlapping or non-overlapping mode selected per run.
- Takes configuration through a valid/ready handshake and arms on start_i.
- Raises a Mealy match strobe on the last bit of each match and counts matches.
- Terminates a run on target count, bit-window timeout or abort, and reports a status code.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_match_core.sv | 62 ++++++
 rtl/seq_det_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_HIT  = 2'b01;
    localparam logic [1:0] ST_TMO  = 2'b10;
    localparam logic [1:0] ST_ABT  = 2'b11;

endpackage

// File: rtl/seq_match_core.sv
// Bit history, fill tracking and variable-length pattern compare.
// The match output is combinational from d_i so the controller can
// raise a Mealy strobe on the completing bit.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             d_i,
    input  logic             d_valid_i,
    input  logic             en,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    input  logic             ovl,
    input  logic             clr,
    output logic             match
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

    logic [PAT_W-1:0] hist_q;
    logic [LEN_W-1:0] fill_q;
    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] mask;
    logic             full;

    // Candidate window = history shifted with the incoming bit; only the
    // low len bits take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        cand    = hist_q << 1;
        cand[0] = d_i;
        full    = (fill_q >= (len - LEN_W'(1)));
        match   = en & d_valid_i & full & ((cand & mask) == (pat & mask));
    end

    // History shifts on every accepted bit; fill restarts after a match
    // only in non-overlapping mode, otherwise saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (en && d_valid_i) begin
            hist_q <= cand;
            if (match && !ovl) begin
                fill_q <= '0;
            end else if (fill_q != FILL_MAX) begin
                fill_q <= fill_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial pattern-detection controller: config handshake,
// run FSM, match/window counters and terminal status reporting.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16,
    localparam int LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [PAT_W-1:0] cfg_pat_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             cfg_ovl_i,
    input  logic [CNT_W-1:0] cfg_target_i,
    input  logic [WIN_W-1:0] cfg_window_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             d_i,
    input  logic             d_valid_i,
    output logic             sd_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       status_o
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [CNT_W-1:0] target_q;
    logic [WIN_W-1:0] window_q;
    logic             cfg_ok_q;

    logic [CNT_W-1:0] cnt_q;
    logic [WIN_W-1:0] win_q;
    logic [1:0]       status_q, status_d;

    logic             core_en;
    logic             match;
    logic             run_clr;
    logic             cnt_inc;
    logic             win_inc;
    logic             hit;
    logic             tmo;

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .d_i       (d_i),
        .d_valid_i (d_valid_i),
        .en        (core_en),
        .pat       (pat_q),
        .len       (len_q),
        .ovl       (ovl_q),
        .clr       (run_clr),
        .match     (match)
    );

    // Configuration is only taken while idle; length validity is
    // resolved once here so the FSM just checks a flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pat_q    <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            target_q <= '0;
            window_q <= '0;
            cfg_ok_q <= 1'b0;
        end else if (state_q == IDLE && cfg_valid_i) begin
            pat_q    <= cfg_pat_i;
            len_q    <= cfg_len_i;
            ovl_q    <= cfg_ovl_i;
            target_q <= cfg_target_i;
            window_q <= cfg_window_i;
            cfg_ok_q <= (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(PAT_W));
        end
    end

    // State and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            status_q <= ST_NONE;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    // Next state and run control; abort outranks target, target outranks
    // timeout when both land on the same bit.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        core_en  = 1'b0;
        run_clr  = 1'b0;
        cnt_inc  = 1'b0;
        win_inc  = 1'b0;
        hit      = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && cfg_ok_q) begin
                    state_d  = HUNT;
                    status_d = ST_NONE;
                    run_clr  = 1'b1;
                end
            end
            HUNT: begin
                core_en = ~abort_i;
                if (abort_i) begin
                    state_d  = DONE;
                    status_d = ST_ABT;
                end else if (d_valid_i) begin
                    win_inc = 1'b1;
                    cnt_inc = match;
                    hit = match && (target_q != '0) &&
                          (CNT_W'(cnt_q + CNT_W'(1)) == target_q);
                    tmo = (window_q != '0) &&
                          (WIN_W'(win_q + WIN_W'(1)) == window_q);
                    if (hit) begin
                        state_d  = DONE;
                        status_d = ST_HIT;
                    end else if (tmo) begin
                        state_d  = DONE;
                        status_d = ST_TMO;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Match and window counters, both saturating, cleared on run start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            win_q <= '0;
        end else if (run_clr) begin
            cnt_q <= '0;
            win_q <= '0;
        end else begin
            if (cnt_inc && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            if (win_inc && win_q != '1) win_q <= win_q + WIN_W'(1);
        end
    end

    assign sd_o        = match;
    assign match_cnt_o = cnt_q;
    assign status_o    = status_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign cfg_ready_o = rst_ni & (state_q == IDLE);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed-vector bench for seq_det_ctrl.
module tb_seq_det_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [7:0] cfg_pat_i;
    logic [3:0] cfg_len_i;
    logic       cfg_ovl_i;
    logic [7:0] cfg_target_i;
    logic [15:0] cfg_window_i;
    logic       start_i;
    logic       abort_i;
    logic       d_i;
    logic       d_valid_i;
    logic       sd_o;
    logic [7:0] match_cnt_o;
    logic       busy_o;
    logic       done_o;
    logic [1:0] status_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    seq_det_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_pat_i    (cfg_pat_i),
        .cfg_len_i    (cfg_len_i),
        .cfg_ovl_i    (cfg_ovl_i),
        .cfg_target_i (cfg_target_i),
        .cfg_window_i (cfg_window_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .d_i          (d_i),
        .d_valid_i    (d_valid_i),
        .sd_o         (sd_o),
        .match_cnt_o  (match_cnt_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .status_o     (status_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic [7:0] tgt, input logic [15:0] win);
        cfg_pat_i = pat; cfg_len_i = len; cfg_ovl_i = ovl;
        cfg_target_i = tgt; cfg_window_i = win;
        cfg_valid_i = 1'b1;
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Present one cycle of input, sample sd_o mid-cycle, then cross the edge.
    task automatic drive_bit(input logic v, input logic b, input logic ab, output logic sd);
        d_valid_i = v; d_i = b; abort_i = ab;
        #2;
        sd = sd_o;
        tick();
        d_valid_i = 1'b0; abort_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %0h want 0", busy_o); else n_pass++;
        n_chk++; if (match_cnt_o !== 8'd0) $display("FAIL rst_cnt: got %0h want 0", match_cnt_o); else n_pass++;
        n_chk++; if (status_o !== 2'b00) $display("FAIL rst_status: got %0h want 0", status_o); else n_pass++;
        n_chk++; if (done_o !== 1'b0) $display("FAIL rst_done: got %0h want 0", done_o); else n_pass++;
        rst_ni = 1'b1;
        tick();
        n_chk++; if (cfg_ready_o !== 1'b1) $display("FAIL rst_ready: got %0h want 1", cfg_ready_o); else n_pass++;
    endtask

    task automatic test_nonovl(input logic ovl);
        logic [6:0] s;
        logic [6:0] e;
        logic sd;
        s = 7'b1011011;
        e = ovl ? 7'b0001001 : 7'b0001000;
        do_cfg(8'b1011, 4'd4, ovl, 8'd0, 16'd0);
        do_start();
        n_chk++; if (cfg_ready_o !== 1'b0) $display("FAIL hunt_ready: got %0h want 0", cfg_ready_o); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            drive_bit(1'b1, s[6-i], 1'b0, sd);
            n_chk++;
            if (sd !== e[6-i]) $display("FAIL ovl%0d_sd bit %0d: got %0h want %0h", ovl, i+1, sd, e[6-i]);
            else n_pass++;
        end
        n_chk++;
        if (match_cnt_o !== (ovl ? 8'd2 : 8'd1))
            $display("FAIL ovl%0d_cnt: got %0d want %0d", ovl, match_cnt_o, ovl ? 2 : 1);
        else n_pass++;
        drive_bit(1'b0, 1'b0, 1'b1, sd);
        n_chk++; if (done_o !== 1'b1) $display("FAIL ovl_end_done: got %0h want 1", done_o); else n_pass++;
        tick();
    endtask

    task automatic test_target();
        logic [7:0] s;
        logic [7:0] e;
        logic sd;
        s = 8'b10111011;
        e = 8'b00010001;
        do_cfg(8'b1011, 4'd4, 1'b0, 8'd2, 16'd0);
        do_start();
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b1, s[7-i], 1'b0, sd);
            n_chk++;
            if (sd !== e[7-i]) $display("FAIL tgt_sd bit %0d: got %0h want %0h", i+1, sd, e[7-i]);
            else n_pass++;
        end
        n_chk++; if (done_o !== 1'b1) $display("FAIL tgt_done: got %0h want 1", done_o); else n_pass++;
        n_chk++; if (status_o !== 2'b01) $display("FAIL tgt_status: got %0h want 1", status_o); else n_pass++;
        n_chk++; if (match_cnt_o !== 8'd2) $display("FAIL tgt_cnt: got %0d want 2", match_cnt_o); else n_pass++;
        tick();
        n_chk++; if (done_o !== 1'b0) $display("FAIL tgt_done_pulse: got %0h want 0", done_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL tgt_busy_after: got %0h want 0", busy_o); else n_pass++;
        n_chk++; if (status_o !== 2'b01) $display("FAIL tgt_status_hold: got %0h want 1", status_o); else n_pass++;
        n_chk++; if (match_cnt_o !== 8'd2) $display("FAIL tgt_cnt_hold: got %0d want 2", match_cnt_o); else n_pass++;
    endtask

    task automatic test_timeout();
        logic sd;
        do_cfg(8'b1011, 4'd4, 1'b0, 8'd0, 16'd5);
        do_start();
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0, 1'b0, sd);
        n_chk++; if (done_o !== 1'b0) $display("FAIL tmo_early_done: got %0h want 0", done_o); else n_pass++;
        drive_bit(1'b1, 1'b0, 1'b0, sd);
        n_chk++; if (done_o !== 1'b1) $display("FAIL tmo_done: got %0h want 1", done_o); else n_pass++;
        n_chk++; if (status_o !== 2'b10) $display("FAIL tmo_status: got %0h want 2", status_o); else n_pass++;
        tick();
        // Target 1 reached on bit 5 of a 5-bit window: target wins.
        do_cfg(8'b1011, 4'd4, 1'b0, 8'd1, 16'd5);
        do_start();
        drive_bit(1'b1, 1'b0, 1'b0, sd);
        drive_bit(1'b1, 1'b1, 1'b0, sd);
        drive_bit(1'b1, 1'b0, 1'b0, sd);
        drive_bit(1'b1, 1'b1, 1'b0, sd);
        n_chk++; if (sd !== 1'b0) $display("FAIL both_sd4: got %0h want 0", sd); else n_pass++;
        drive_bit(1'b1, 1'b1, 1'b0, sd);
        n_chk++; if (sd !== 1'b1) $display("FAIL both_sd5: got %0h want 1", sd); else n_pass++;
        n_chk++; if (status_o !== 2'b01) $display("FAIL both_status: got %0h want 1", status_o); else n_pass++;
        n_chk++; if (match_cnt_o !== 8'd1) $display("FAIL both_cnt: got %0d want 1", match_cnt_o); else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        logic sd;
        do_cfg(8'b1011, 4'd4, 1'b1, 8'd0, 16'd0);
        do_start();
        drive_bit(1'b1, 1'b1, 1'b0, sd);
        drive_bit(1'b1, 1'b0, 1'b0, sd);
        drive_bit(1'b1, 1'b1, 1'b0, sd);
        drive_bit(1'b1, 1'b1, 1'b1, sd);
        n_chk++; if (sd !== 1'b0) $display("FAIL abt_sd: got %0h want 0", sd); else n_pass++;
        n_chk++; if (status_o !== 2'b11) $display("FAIL abt_status: got %0h want 3", status_o); else n_pass++;
        n_chk++; if (match_cnt_o !== 8'd0) $display("FAIL abt_cnt: got %0d want 0", match_cnt_o); else n_pass++;
        n_chk++; if (done_o !== 1'b1) $display("FAIL abt_done: got %0h want 1", done_o); else n_pass++;
        tick();
    endtask

    task automatic test_gaps();
        logic [6:0] s;
        logic [6:0] e;
        logic sd;
        s = 7'b1011011;
        e = 7'b0001000;
        do_cfg(8'b1011, 4'd4, 1'b0, 8'd0, 16'd0);
        do_start();
        for (int i = 0; i < 7; i++) begin
            drive_bit(1'b0, ~s[6-i], 1'b0, sd);
            n_chk++; if (sd !== 1'b0) $display("FAIL gap_sd idle %0d: got %0h want 0", i, sd); else n_pass++;
            drive_bit(1'b1, s[6-i], 1'b0, sd);
            n_chk++;
            if (sd !== e[6-i]) $display("FAIL gap_sd bit %0d: got %0h want %0h", i+1, sd, e[6-i]);
            else n_pass++;
        end
        n_chk++; if (match_cnt_o !== 8'd1) $display("FAIL gap_cnt: got %0d want 1", match_cnt_o); else n_pass++;
        drive_bit(1'b0, 1'b0, 1'b1, sd);
        tick();
    endtask

    task automatic test_len();
        logic [3:0] s;
        logic sd;
        do_cfg(8'b1011, 4'd0, 1'b0, 8'd0, 16'd0);
        do_start();
        n_chk++; if (busy_o !== 1'b0) $display("FAIL len0_busy: got %0h want 0", busy_o); else n_pass++;
        do_cfg(8'b1011, 4'd9, 1'b0, 8'd0, 16'd0);
        do_start();
        n_chk++; if (busy_o !== 1'b0) $display("FAIL len9_busy: got %0h want 0", busy_o); else n_pass++;
        // Single-bit pattern: every 1 is a match.
        s = 4'b1011;
        do_cfg(8'h01, 4'd1, 1'b0, 8'd3, 16'd0);
        do_start();
        n_chk++; if (busy_o !== 1'b1) $display("FAIL len1_busy: got %0h want 1", busy_o); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive_bit(1'b1, s[3-i], 1'b0, sd);
            n_chk++;
            if (sd !== s[3-i]) $display("FAIL len1_sd bit %0d: got %0h want %0h", i+1, sd, s[3-i]);
            else n_pass++;
        end
        n_chk++; if (status_o !== 2'b01) $display("FAIL len1_status: got %0h want 1", status_o); else n_pass++;
        n_chk++; if (match_cnt_o !== 8'd3) $display("FAIL len1_cnt: got %0d want 3", match_cnt_o); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        logic sd;
        do_cfg(8'b1011, 4'd4, 1'b0, 8'd0, 16'd0);
        do_start();
        drive_bit(1'b1, 1'b1, 1'b0, sd);
        drive_bit(1'b1, 1'b0, 1'b0, sd);
        drive_bit(1'b1, 1'b1, 1'b0, sd);
        drive_bit(1'b1, 1'b1, 1'b0, sd);
        n_chk++; if (match_cnt_o !== 8'd1) $display("FAIL mid_cnt_pre: got %0d want 1", match_cnt_o); else n_pass++;
        d_valid_i = 1'b1; d_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL mid_busy: got %0h want 0", busy_o); else n_pass++;
        n_chk++; if (match_cnt_o !== 8'd0) $display("FAIL mid_cnt: got %0d want 0", match_cnt_o); else n_pass++;
        n_chk++; if (sd_o !== 1'b0) $display("FAIL mid_sd: got %0h want 0", sd_o); else n_pass++;
        n_chk++; if (cfg_ready_o !== 1'b0) $display("FAIL mid_ready: got %0h want 0", cfg_ready_o); else n_pass++;
        n_chk++; if (status_o !== 2'b00) $display("FAIL mid_status: got %0h want 0", status_o); else n_pass++;
        d_valid_i = 1'b0;
        #2 rst_ni = 1'b1;
        tick();
        n_chk++; if (cfg_ready_o !== 1'b1) $display("FAIL mid_ready_rel: got %0h want 1", cfg_ready_o); else n_pass++;
    endtask

    initial begin
        cfg_valid_i = 1'b0; cfg_pat_i = '0; cfg_len_i = '0; cfg_ovl_i = 1'b0;
        cfg_target_i = '0; cfg_window_i = '0;
        start_i = 1'b0; abort_i = 1'b0; d_i = 1'b0; d_valid_i = 1'b0;
        test_reset();
        test_nonovl(1'b0);
        test_nonovl(1'b1);
        test_target();
        test_timeout();
        test_abort();
        test_gaps();
        test_len();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
